// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the CPU bus slave: FSM states, request kinds,
// I/O register offsets and STATUS layout.
package bus_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_HOLD = 2'd3
   } bus_state_t;

   typedef enum logic [1:0] {
      OP_READ    = 2'd0,
      OP_WRITE   = 2'd1,
      OP_ILLEGAL = 2'd2
   } bus_op_t;

   localparam logic [7:0] IO_GPIO_OUT = 8'd0;
   localparam logic [7:0] IO_GPIO_IN  = 8'd1;
   localparam logic [7:0] IO_TICK     = 8'd2;
   localparam logic [7:0] IO_STATUS   = 8'd3;

   localparam int STATUS_ERR_BIT = 0;

   function automatic logic [7:0] status_word(input logic err);
      logic [7:0] w;
      w = 8'h00;
      w[STATUS_ERR_BIT] = err;
      return w;
   endfunction

endpackage

// File: rtl/bus_ram.sv
// Single-port RAM behind the bus slave; write and registered read share one address.
module bus_ram #(
   parameter int DEPTH = 240
) (
   input  logic       clk,
   input  logic       i_we,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_wdata,
   output logic [7:0] o_rdata
);

   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_ctrl.sv
// CPU bus slave: decodes RAM and memory-mapped I/O, inserts RAM wait states,
// returns a one-cycle ready pulse and holds off new requests until strobes drop.
module bus_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter int         RAM_WAIT = 1,
   parameter logic [7:0] IO_BASE  = 8'hF0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] address,
   input  logic [7:0] data_wr,
   output logic [7:0] data_rd,
   input  logic       read,
   input  logic       write,
   output logic       ready,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out,
   output logic       bus_err
);

   bus_state_t r_state;
   bus_state_t w_state_next;
   bus_op_t    r_op;
   logic [3:0] r_cnt;
   logic [7:0] r_addr, r_wdata, r_tick, r_tick_cap;
   logic [7:0] r_sync1, r_sync2, r_gpio_out, r_data_rd;
   logic       r_bus_err;
   logic       w_accept, w_access, w_ready, w_is_ram, w_ram_we;
   logic [7:0] w_io_off, w_ram_addr, w_ram_rdata, w_io_rdata;

   assign w_accept   = (r_state == ST_IDLE) && (read || write);
   assign w_is_ram   = r_addr < IO_BASE;
   assign w_io_off   = r_addr - IO_BASE;
   // The RAM sees the live bus address while idle so its registered read is
   // already valid when a zero-wait access completes.
   assign w_ram_addr = (r_state == ST_IDLE) ? address : r_addr;
   assign w_ram_we   = w_access && (r_op == OP_WRITE) && w_is_ram;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (read || write) w_state_next = ST_WAIT;
         ST_WAIT: if (r_cnt == 4'd0) w_state_next = ST_RESP;
         ST_RESP: w_state_next = ST_HOLD;
         ST_HOLD: if (!read && !write) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready  = 1'b0;
      w_access = 1'b0;
      case (r_state)
         ST_WAIT: w_access = (r_cnt == 4'd0);
         ST_RESP: w_ready  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op       <= OP_READ;
         r_addr     <= 8'h00;
         r_wdata    <= 8'h00;
         r_cnt      <= 4'd0;
         r_tick_cap <= 8'h00;
      end else if (w_accept) begin
         r_addr     <= address;
         r_wdata    <= data_wr;
         r_tick_cap <= r_tick;
         if (read && write) begin
            r_op  <= OP_ILLEGAL;
            r_cnt <= 4'd0;
         end else begin
            r_op  <= read ? OP_READ : OP_WRITE;
            r_cnt <= (address < IO_BASE) ? 4'(RAM_WAIT) : 4'd0;
         end
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tick  <= 8'h00;
         r_sync1 <= 8'h00;
         r_sync2 <= 8'h00;
      end else begin
         r_tick  <= r_tick + 8'd1;
         r_sync1 <= gpio_in;
         r_sync2 <= r_sync1;
      end
   end

   always_comb begin
      w_io_rdata = 8'h00;
      case (w_io_off)
         IO_GPIO_OUT: w_io_rdata = r_gpio_out;
         IO_GPIO_IN:  w_io_rdata = r_sync2;
         IO_TICK:     w_io_rdata = r_tick_cap;
         IO_STATUS:   w_io_rdata = status_word(r_bus_err);
         default:     ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gpio_out <= 8'h00;
         r_bus_err  <= 1'b0;
         r_data_rd  <= 8'h00;
      end else begin
         if (w_accept && read && write) begin
            r_bus_err <= 1'b1;
         end
         if (w_access) begin
            case (r_op)
               OP_READ:  r_data_rd <= w_is_ram ? w_ram_rdata : w_io_rdata;
               OP_WRITE: begin
                  if (!w_is_ram && (w_io_off == IO_GPIO_OUT)) begin
                     r_gpio_out <= r_wdata;
                  end
                  if (!w_is_ram && (w_io_off == IO_STATUS) && r_wdata[STATUS_ERR_BIT]) begin
                     r_bus_err <= 1'b0;
                  end
               end
               default:  r_data_rd <= 8'h00;
            endcase
         end
      end
   end

   bus_ram #(
      .DEPTH(int'(IO_BASE))
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_rdata)
   );

   assign data_rd  = r_data_rd;
   assign ready    = w_ready;
   assign gpio_out = r_gpio_out;
   assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_bus_ctrl.sv
// Bench for bus_ctrl: directed transfers with a scoreboard on the main instance,
// plus a second instance with three RAM wait states for the mid-transfer reset case.
module tb_bus_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b0, read = 1'b0, write = 1'b0, ready, bus_err;
   logic [7:0] address = 8'h00, data_wr = 8'h00, data_rd, gpio_in = 8'h00, gpio_out;

   logic       reset3 = 1'b0, read3 = 1'b0, write3 = 1'b0, ready3, bus_err3;
   logic [7:0] address3 = 8'h00, data_wr3 = 8'h00, data_rd3, gpio_in3 = 8'h00, gpio_out3;

   bus_ctrl #(.RAM_WAIT(1), .IO_BASE(8'hF0)) dut (
      .clk(clk), .reset(reset), .address(address), .data_wr(data_wr),
      .data_rd(data_rd), .read(read), .write(write), .ready(ready),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .bus_err(bus_err)
   );

   bus_ctrl #(.RAM_WAIT(3), .IO_BASE(8'hF0)) dut3 (
      .clk(clk), .reset(reset3), .address(address3), .data_wr(data_wr3),
      .data_rd(data_rd3), .read(read3), .write(write3), .ready(ready3),
      .gpio_in(gpio_in3), .gpio_out(gpio_out3), .bus_err(bus_err3)
   );

   typedef struct {
      logic [7:0] d;
      logic [7:0] g;
      logic       e;
      int         cyc;
      string      name;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic [7:0] tick_m;
   logic [7:0] last_rd = 8'h00;
   logic [7:0] gpio_m  = 8'h00;
   logic       err_m   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge reset) begin
      if (reset) tick_m <= 8'h00;
      else       tick_m <= tick_m + 8'd1;
   end

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h required %02h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding transfer.
   always @(negedge clk) begin
      if (!reset && ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1 at cycle %0d required no pending transfer", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk8({mon_e.name, "/data_rd"}, data_rd, mon_e.d);
            chk8({mon_e.name, "/gpio_out"}, gpio_out, mon_e.g);
            chk8({mon_e.name, "/bus_err"}, {7'b0, bus_err}, {7'b0, mon_e.e});
            chk_int({mon_e.name, "/ready_cycle"}, cyc, mon_e.cyc);
            $display("[TB] %s done at cycle %0d data_rd=%02h", mon_e.name, cyc, data_rd);
         end
      end
   end

   // Called just after a clock edge with the DUT idle; returns the same way.
   task automatic xfer(input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] exp_rd,
                       input int hold, input string nm);
      exp_t e;
      int   wt;
      bit   got;
      wt = (rd && wr) ? 0 : ((a < 8'hF0) ? 1 : 0);
      if (rd && wr) begin
         last_rd = 8'h00;
         err_m   = 1'b1;
      end else if (rd) begin
         last_rd = exp_rd;
      end else begin
         if (a == 8'hF0) gpio_m = wd;
         if (a == 8'hF3 && wd[0]) err_m = 1'b0;
      end
      e.d = last_rd; e.g = gpio_m; e.e = err_m; e.cyc = cyc + 2 + wt; e.name = nm;
      sb.push_back(e);
      address = a; data_wr = wd; read = rd; write = wr;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = (ready === 1'b1);
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s/timeout: got no ready required ready within 40 cycles", nm);
         sb.delete(sb.size() - 1);
      end
      repeat (hold + 1) @(posedge clk);
      #1;
      read = 1'b0; write = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(input logic [7:0] v);
      for (int i = 0; i < 300 && tick_m != v; i++) begin
         @(posedge clk);
         #1;
      end
      chk8("tick_align", tick_m, v);
   endtask

   task automatic x3(input logic rd, input logic wr, input logic [7:0] a,
                     input logic [7:0] wd, input string nm);
      bit got;
      address3 = a; data_wr3 = wd; read3 = rd; write3 = wr;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = (ready3 === 1'b1);
      end
      chk8({nm, "/ready"}, {7'b0, got}, 8'h01);
      @(posedge clk);
      #1;
      read3 = 1'b0; write3 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_rdy;
      #1;
      reset = 1'b1; reset3 = 1'b1;
      #1;
      chk8("reset/data_rd", data_rd, 8'h00);
      chk8("reset/ready", {7'b0, ready}, 8'h00);
      chk8("reset/gpio_out", gpio_out, 8'h00);
      chk8("reset/bus_err", {7'b0, bus_err}, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; reset3 = 1'b0;
      @(posedge clk);
      #1;

      xfer(0, 1, 8'h20, 8'h77, 8'h00, 0, "wr_ram20");
      xfer(0, 1, 8'h10, 8'h5A, 8'h00, 0, "wr_ram10");
      xfer(1, 0, 8'h10, 8'h00, 8'h5A, 0, "rd_ram10");
      xfer(0, 1, 8'hF0, 8'hA5, 8'h00, 0, "wr_gpio_out");
      xfer(1, 0, 8'hF0, 8'h00, 8'hA5, 0, "rd_gpio_out");
      gpio_in = 8'h3C;
      repeat (3) @(posedge clk);
      #1;
      xfer(1, 0, 8'hF1, 8'h00, 8'h3C, 0, "rd_gpio_in");
      xfer(0, 1, 8'hF1, 8'hFF, 8'h00, 0, "wr_gpio_in_ro");
      xfer(1, 0, 8'hF1, 8'h00, 8'h3C, 0, "rd_gpio_in_again");
      xfer(1, 0, 8'hF0, 8'h00, 8'hA5, 0, "rd_gpio_out_again");
      xfer(1, 0, 8'hF7, 8'h00, 8'h00, 0, "rd_unmapped");
      xfer(0, 1, 8'hF7, 8'h99, 8'h00, 0, "wr_unmapped");

      wait_tick(8'hFD);
      xfer(1, 0, 8'hF2, 8'h00, 8'hFD, 0, "rd_tick_a");
      wait_tick(8'h04);
      xfer(1, 0, 8'hF2, 8'h00, 8'h04, 0, "rd_tick_b");

      xfer(1, 1, 8'h20, 8'h00, 8'h00, 0, "illegal");
      xfer(1, 0, 8'h20, 8'h00, 8'h77, 0, "rd_ram20_kept");
      xfer(1, 0, 8'hF3, 8'h00, 8'h01, 0, "rd_status_set");
      xfer(0, 1, 8'hF3, 8'h01, 8'h00, 0, "clr_status");
      xfer(1, 0, 8'hF3, 8'h00, 8'h00, 0, "rd_status_clr");

      xfer(1, 0, 8'h10, 8'h00, 8'h5A, 5, "rd_hold");
      xfer(1, 0, 8'hF0, 8'h00, 8'hA5, 0, "rd_after_hold");

      repeat (3) @(posedge clk);
      chk_int("scoreboard_drained", sb.size(), 0);

      x3(1, 1, 8'h00, 8'h00, "r3_illegal");
      chk8("r3/bus_err_set", {7'b0, bus_err3}, 8'h01);
      x3(0, 1, 8'hF0, 8'hC3, "r3_wr_gpio");
      chk8("r3/gpio_out", gpio_out3, 8'hC3);
      x3(1, 0, 8'hF0, 8'h00, "r3_rd_gpio");
      chk8("r3/data_rd", data_rd3, 8'hC3);
      address3 = 8'h30; read3 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset3 = 1'b1;
      #1;
      chk8("r3_rst/ready", {7'b0, ready3}, 8'h00);
      chk8("r3_rst/data_rd", data_rd3, 8'h00);
      chk8("r3_rst/gpio_out", gpio_out3, 8'h00);
      chk8("r3_rst/bus_err", {7'b0, bus_err3}, 8'h00);
      read3 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset3 = 1'b0;
      n_rdy = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ready3 === 1'b1) n_rdy++;
      end
      chk_int("r3_rst/no_ready_after_release", n_rdy, 0);
      @(posedge clk);
      #1;
      x3(1, 0, 8'hF0, 8'h00, "r3_rd_after_reset");
      chk8("r3_after/data_rd", data_rd3, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Memory/peripheral bus slave directly downstream of the 8-bit CPU.
- Consumes the CPU's address, write data, read and write strobes, and returns read data plus a one-cycle ready pulse.
- Decodes one shared 8-bit address space into internal RAM and a small bank of memory-mapped I/O registers.
- Inserts programmable wait states for RAM accesses.

Parameters:
- RAM_WAIT, 1, extra cycles between request acceptance and ready for RAM accesses (0..15).
- IO_BASE, 8'hF0, first I/O address; addresses below it map to RAM.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- address  input  8  CPU address bus
- data_wr  input  8  write data from CPU data_out
- data_rd  output  8  read data to CPU data_in
- read  input  1  CPU read request, level, held until ready
- write  input  1  CPU write request, level, held until ready
- ready  output  1  transfer complete, one-cycle pulse
- gpio_in  input  8  asynchronous external input pins
- gpio_out  output  8  output port register
- bus_err  output  1  sticky error flag (mirror of STATUS bit0)

Behaviour:
- Reset: applied asynchronously; every output is 0 immediately. This covers data_rd=0x00, ready=0, gpio_out=0x00 and bus_err=0. FSM goes to IDLE and TICK=0x00. RAM contents are not reset.
- Address map:
  - 0x00..IO_BASE-1: RAM, read/write.
  - IO_BASE+0 GPIO_OUT: read/write.
  - +1 GPIO_IN: read-only; gpio_in is synchronized through 2 flops; writes are ignored.
  - +2 TICK: read-only; free-running counter, +1 every cycle, wraps 0xFF->0x00.
  - +3 STATUS: bit0=bus_err, other bits read 0; writing 1 to bit0 clears it.
  - Remaining I/O addresses: read 0x00, writes ignored, no error.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - On read XOR write, latch address, data_wr and op. Load the wait counter with RAM_WAIT (RAM) or 0 (I/O). Go to WAIT.
  - A TICK read captures the counter value at this acceptance edge.
- Illegal request: read AND write both high in IDLE.
  - Access is suppressed and bus_err is set.
  - The response is data 0x00; the FSM goes to WAIT with counter 0.
- WAIT: decrement the counter. When it is 0, perform the access on that edge and go to RESP.
  - RAM write or GPIO_OUT write updates storage.
  - Read data is registered into data_rd.
- RESP: ready=1 for exactly this cycle; data_rd is valid. Go to HOLD.
- HOLD: stay until read=0 and write=0, then go to IDLE. No new request is accepted before that, so a strobe held high does not cause a second transfer.
- Latency, counted from the acceptance edge T0 (request sampled high in IDLE):
  - ready is high in cycle T0+2+wait.
  - RAM_WAIT=1 gives RAM ready at T0+3 and I/O ready at T0+2.
- data_rd holds its last value until the next read response; writes do not change it.
- Strobes dropping before ready are a protocol violation. The transfer still completes, and HOLD exits on the next cycle.
- Reset mid-transfer: the transfer is aborted and ready is never produced. A RAM write in flight may or may not have landed.
- A STATUS W1C clear and a simultaneous illegal request cannot coincide, because transfers are serialized.

Decomposition:
- Shared header alongside the existing type definitions holds:
  - bus FSM state encodings;
  - I/O register offsets (GPIO_OUT=0, GPIO_IN=1, TICK=2, STATUS=3);
  - STATUS bit index.
- One sub-module, bus_ram: synchronous single-port IO_BASE x 8 array with write enable and a registered read, written at the WAIT-exit edge.
- Address decode, FSM, wait counter, I/O registers and synchronizer live in bus_ctrl.

Test Plan:
- RAM write/read, RAM_WAIT=1: write 0x5A to 0x10, drop strobe, then read 0x10. Required: ready exactly 3 cycles after each acceptance, data_rd=0x5A.
- GPIO: write 0xA5 to 0xF0. Required: gpio_out=0xA5 from the ready cycle onward; read 0xF0 returns 0xA5. Drive gpio_in=0x3C for 3+ cycles, then read 0xF1. Required: 0x3C. Write to 0xF1 changes nothing.
- TICK: read 0xF2 accepted at cycle N, then again at cycle N+7. Required: values differ by 7 mod 256; start near 0xFD to cover wrap.
- Error: assert read and write together at 0x20. Required: ready pulse, data_rd=0x00, bus_err=1, RAM[0x20] unchanged. Read 0xF3 returns 0x01; write 0x01 to 0xF3 clears bus_err to 0.
- Hold: keep read high for 5 cycles after ready. Required: exactly one ready pulse; the next request is accepted only after the strobe is low for at least 1 cycle.
- Reset mid-WAIT, RAM_WAIT=3: assert reset during WAIT. Required: ready, data_rd, gpio_out and bus_err all 0 immediately; no ready after reset release until a new request.
